// File: rtl/fir_decimator.sv
// -----------------------------------------------------------------------------
// fir_decimator
//
// Purpose:
//   Downstream stage of the FIR filter. It takes the signed filtered sample
//   stream and decimates it by a runtime-selectable ratio R = 2^k, where
//   k = 0..LOG2R_MAX. The filter uses accumulate-and-dump averaging, so each
//   output is the mean of R accepted input samples. One averaged sample is
//   produced for every R accepted inputs, and a one-cycle valid pulse marks it.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   en_i           global enable; 0 holds all state and ignores inputs
//   clear_i        synchronous abort of the current block (only acts when en_i=1)
//   in_valid_i     in_data_i carries a new FIR output sample this cycle
//   in_data_i      signed two's-complement FIR output sample
//   ratio_sel_i    decimation exponent k; values above LOG2R_MAX are clamped
//   out_data_o     signed decimated sample; holds its value until the next dump
//   out_valid_o    one-cycle pulse; out_data_o was updated on this cycle's edge
//   busy_o         high while a block is partially accumulated
//
// Notes:
//   LOG2R_MAX must be at least 1. ACC_W = DATA_W + LOG2R_MAX is wide enough
//   that the sum of 2^LOG2R_MAX full-scale samples cannot overflow.
// -----------------------------------------------------------------------------
module fir_decimator #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LOG2R_MAX = 3,
  parameter int unsigned ACC_W     = DATA_W + LOG2R_MAX
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             en_i,
  input  logic                             clear_i,
  input  logic                             in_valid_i,
  input  logic [DATA_W-1:0]                in_data_i,
  input  logic [$clog2(LOG2R_MAX+1)-1:0]   ratio_sel_i,
  output logic [DATA_W-1:0]                out_data_o,
  output logic                             out_valid_o,
  output logic                             busy_o
);

  localparam int unsigned SelW = $clog2(LOG2R_MAX + 1);
  localparam int unsigned CntW = LOG2R_MAX;
  localparam logic [SelW-1:0] KMax = SelW'(LOG2R_MAX);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [SelW-1:0]          k_q, k_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic                     block_start;
  logic [SelW-1:0]          k_sel_clamped;
  logic [SelW-1:0]          k_eff;
  logic [CntW-1:0]          last_cnt;
  logic                     dump;
  logic signed [ACC_W-1:0]  in_sext;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  sum;

  // When the counter is 0, the next accepted sample opens a new block.
  assign block_start   = (cnt_q == '0);
  assign k_sel_clamped = (ratio_sel_i > KMax) ? KMax : ratio_sel_i;

  // The first sample of a block uses the live selector. Later samples use the
  // exponent latched at block start, so a ratio change mid-block has no effect
  // until the next block.
  assign k_eff = block_start ? k_sel_clamped : k_q;

  // The terminal count is 2^k - 1: a mask with the low k bits set.
  always_comb begin
    last_cnt = '0;
    for (int i = 0; i < int'(CntW); i++) begin
      last_cnt[i] = (i < int'(k_eff));
    end
  end

  assign dump = (cnt_q == last_cnt);

  assign in_sext  = {{(ACC_W - DATA_W){in_data_i[DATA_W-1]}}, in_data_i};

  // A new block starts from zero. The stale accumulator left by the previous
  // dump or by a clear is discarded here rather than zeroed at dump time.
  assign acc_base = block_start ? '0 : acc_q;
  assign sum      = acc_base + in_sext;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    k_d         = k_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    if (en_i) begin
      if (clear_i) begin
        // Clear takes priority over a sample presented in the same cycle.
        cnt_d = '0;
        acc_d = '0;
      end else if (in_valid_i) begin
        if (block_start) begin
          k_d = k_sel_clamped;
        end
        if (dump) begin
          // Arithmetic shift gives the floor of the mean. The result always
          // fits in DATA_W, so truncating to DATA_W bits is lossless.
          out_data_d  = DATA_W'(sum >>> k_eff);
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (cnt_q != '0);

endmodule

// File: tb/tb_fir_decimator.sv
// -----------------------------------------------------------------------------
// tb_fir_decimator
//
// Self-checking bench for fir_decimator. It runs directed scenarios first and
// then a randomized stream. Expected outputs come from a block-level model that
// keeps the current block's samples in a queue and averages them with integer
// floor division.
// -----------------------------------------------------------------------------
module tb_fir_decimator;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned LOG2R_MAX = 3;
  localparam int unsigned SEL_W     = $clog2(LOG2R_MAX + 1);

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              clr;
  logic              vld;
  logic [DATA_W-1:0] data;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;

  int checks = 0;
  int passes = 0;

  // Reference model state
  int blk[$];
  int mk;
  int mout;
  bit mvalid;

  fir_decimator #(
    .DATA_W    (DATA_W),
    .LOG2R_MAX (LOG2R_MAX)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .clear_i     (clr),
    .in_valid_i  (vld),
    .in_data_i   (data),
    .ratio_sel_i (sel),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int floor_div(input int num, input int den);
    int q;
    q = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    return q;
  endfunction

  function automatic void model_step(input bit e, input bit c, input bit v, input int d,
                                     input int s);
    int total;
    mvalid = 1'b0;
    if (!e) return;
    if (c) begin
      blk.delete();
      return;
    end
    if (!v) return;
    if (blk.size() == 0) mk = (s > int'(LOG2R_MAX)) ? int'(LOG2R_MAX) : s;
    blk.push_back(d);
    if (blk.size() == (1 << mk)) begin
      total = 0;
      foreach (blk[i]) total += blk[i];
      mout   = floor_div(total, 1 << mk);
      mvalid = 1'b1;
      blk.delete();
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag,
                $signed(obs), obs, $signed(exp), exp);
  endtask

  function automatic logic [31:0] sx(input logic [DATA_W-1:0] v);
    return {{(32 - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Drive one cycle of inputs, advance the model, then check the outputs 1ns after the edge.
  task automatic step(input bit e, input bit c, input bit v, input int d, input int s);
    en   = e;
    clr  = c;
    vld  = v;
    data = DATA_W'(d);
    sel  = SEL_W'(s);
    model_step(e, c, v, int'($signed(data)), int'(sel));
    @(posedge clk);
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, mvalid});
    chk("out_data", sx(out_data), mout);
    chk("busy", {31'b0, busy}, {31'b0, (blk.size() != 0)});
  endtask

  task automatic do_reset();
    en     = 1'b0;
    clr    = 1'b0;
    vld    = 1'b0;
    rst_n  = 1'b0;
    blk.delete();
    mk     = 0;
    mout   = 0;
    mvalid = 1'b0;
    #2;
    chk("rst_out_data", sx(out_data), 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    vld   = 1'b0;
    data  = '0;
    sel   = '0;
    do_reset();

    // 1: k=2, 10,20,30,40 -> 25
    step(1, 0, 1, 10, 2); chk("t1_busy1", {31'b0, busy}, 32'd1);
    step(1, 0, 1, 20, 2); chk("t1_busy2", {31'b0, busy}, 32'd1);
    step(1, 0, 1, 30, 2); chk("t1_busy3", {31'b0, busy}, 32'd1);
    chk("t1_novalid", {31'b0, out_valid}, 32'd0);
    step(1, 0, 1, 40, 2);
    chk("t1_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_data", sx(out_data), 32'd25);
    chk("t1_idle", {31'b0, busy}, 32'd0);
    step(1, 0, 0, 0, 2);
    chk("t1_pulse_end", {31'b0, out_valid}, 32'd0);
    chk("t1_hold", sx(out_data), 32'd25);

    // 2: k=1, floor of negative mean
    step(1, 0, 1, -3, 1);
    step(1, 0, 1, -4, 1);
    chk("t2_neg", sx(out_data), -32'sd4);
    step(1, 0, 1, 5, 1);
    step(1, 0, 1, 6, 1);
    chk("t2_pos", sx(out_data), 32'd5);

    // 3: k=3 full-scale blocks
    for (int i = 0; i < 8; i++) step(1, 0, 1, -128, 3);
    chk("t3_min", sx(out_data), -32'sd128);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 127, 3);
    chk("t3_max", sx(out_data), 32'd127);

    // 4: k=0 ramp with a gap after each sample
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, i, 0);
      chk("t4_valid", {31'b0, out_valid}, 32'd1);
      chk("t4_data", sx(out_data), i);
      step(1, 0, 0, 0, 0);
      chk("t4_gap", {31'b0, out_valid}, 32'd0);
    end

    // 5: ratio change mid-block is deferred
    step(1, 0, 1, 1, 2);
    step(1, 0, 1, 2, 2);
    step(1, 0, 1, 3, 1);
    chk("t5_no_early", {31'b0, out_valid}, 32'd0);
    step(1, 0, 1, 6, 1);
    chk("t5_dump4", {31'b0, out_valid}, 32'd1);
    chk("t5_data", sx(out_data), 32'd3);
    step(1, 0, 1, 10, 1);
    step(1, 0, 1, 20, 1);
    chk("t5_r2", sx(out_data), 32'd15);

    // 6: clear discards partial sum; clear beats valid
    for (int i = 0; i < 3; i++) step(1, 0, 1, 100, 2);
    step(1, 1, 1, 100, 2);
    chk("t6_clr_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 8, 2);
    chk("t6_clr_data", sx(out_data), 32'd8);
    // same with reset instead of clear
    for (int i = 0; i < 3; i++) step(1, 0, 1, 100, 2);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 1, 8, 2);
    chk("t6_rst_data", sx(out_data), 32'd8);

    // en=0 holds state mid-block
    step(1, 0, 1, 4, 1);
    step(0, 0, 1, 50, 3);
    step(0, 1, 1, 50, 3);
    chk("en0_busy", {31'b0, busy}, 32'd1);
    step(1, 0, 1, 6, 3);
    chk("en0_data", sx(out_data), 32'd5);

    // Randomized stream
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) < 7), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
